// File: rtl/func_scan_pkg.sv
// Shared definitions for the function-table scanner.
// - scan_state_t   : FSM state encoding used by func_table_scanner
// - N_IN_DEF       : default input-code width of the function block under test
// - FUNC_TABLE_DEF : the team's reference 3-input function table
package func_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        COMPARE,
        DONE
    } scan_state_t;

    localparam int         N_IN_DEF       = 3;
    localparam logic [7:0] FUNC_TABLE_DEF = 8'h5A;

endpackage

// File: rtl/popcnt_first.sv
// Combinational mismatch analysis of a truth-table difference vector.
// Ports:
//   diff_i  in   2**N_IN  captured table XOR expected table
//   cnt_o   out  N_IN+1   number of set bits in diff_i (can reach 2**N_IN)
//   first_o out  N_IN     lowest set bit position of diff_i, 0 when diff_i is 0
module popcnt_first #(
    parameter int N_IN = 3
) (
    input  logic [2**N_IN-1:0] diff_i,
    output logic [N_IN:0]      cnt_o,
    output logic [N_IN-1:0]    first_o
);

    // Walking from the top down lets the last hit overwrite first_o, leaving
    // the lowest mismatching index.
    always_comb begin
        cnt_o   = '0;
        first_o = '0;
        for (int i = 2**N_IN - 1; i >= 0; i--) begin
            cnt_o = cnt_o + (N_IN+1)'(diff_i[i]);
            if (diff_i[i]) begin
                first_o = N_IN'(i);
            end
        end
    end

endmodule

// File: rtl/func_table_scanner.sv
// Reads back the truth table of a combinational N_IN-input function block.
// Sweeps sel_out over every code, holds each code for SETTLE cycles, samples
// fn_in, then compares the captured table with the expected table latched at
// start.
// Ports:
//   clk            in   1        clock, all state changes on posedge
//   reset_n        in   1        synchronous active-low reset
//   start          in   1        scan request, honoured only in IDLE
//   exp_table      in   2**N_IN  expected table (bit i = f(i)), latched at start
//   fn_in          in   1        output of the function block under test
//   sel_out        out  N_IN     code driven to the function block
//   busy           out  1        high from start acceptance through DONE
//   done           out  1        one-cycle pulse, results valid
//   table_out      out  2**N_IN  captured table
//   match          out  1        table_out equals the latched expected table
//   mismatch_cnt   out  N_IN+1   number of mismatching entries
//   first_bad_idx  out  N_IN     lowest mismatching index, 0 on match
module func_table_scanner
    import func_scan_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [2**N_IN-1:0]   exp_table,
    input  logic                 fn_in,
    output logic [N_IN-1:0]      sel_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 match,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN-1:0]      first_bad_idx
);

    localparam int              TW          = 2**N_IN;
    localparam logic [N_IN-1:0] IDX_LAST    = N_IN'(TW - 1);
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

    scan_state_t       state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [3:0]        settle_q, settle_d;
    logic [TW-1:0]     exp_q, exp_d;
    logic [TW-1:0]     table_q, table_d;
    logic              match_q, match_d;
    logic [N_IN:0]     cnt_q, cnt_d;
    logic [N_IN-1:0]   first_q, first_d;

    logic [TW-1:0]     diff;
    logic [N_IN:0]     pc_cnt;
    logic [N_IN-1:0]   pc_first;

    assign diff = table_q ^ exp_q;

    popcnt_first #(
        .N_IN (N_IN)
    ) u_popcnt_first (
        .diff_i  (diff),
        .cnt_o   (pc_cnt),
        .first_o (pc_first)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            exp_q    <= '0;
            table_q  <= '0;
            match_q  <= 1'b0;
            cnt_q    <= '0;
            first_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            exp_q    <= exp_d;
            table_q  <= table_d;
            match_q  <= match_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        exp_d    = exp_q;
        table_d  = table_q;
        match_d  = match_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        busy     = (state_q != IDLE);
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d    = exp_table;
                    table_d  = '0;
                    match_d  = 1'b0;
                    cnt_d    = '0;
                    first_d  = '0;
                    idx_d    = '0;
                    settle_d = '0;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                settle_d = settle_q + 4'd1;
                if (settle_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                table_d[idx_q] = fn_in;
                // Terminal test before increment keeps idx from wrapping, so
                // sel_out parks on the last code after the scan.
                if (idx_q == IDX_LAST) begin
                    state_d = COMPARE;
                end else begin
                    idx_d    = idx_q + 1'b1;
                    settle_d = '0;
                    state_d  = DRIVE;
                end
            end
            COMPARE: begin
                match_d = (diff == '0);
                cnt_d   = pc_cnt;
                first_d = pc_first;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sel_out       = idx_q;
    assign table_out     = table_q;
    assign match         = match_q;
    assign mismatch_cnt  = cnt_q;
    assign first_bad_idx = first_q;

endmodule

// File: tb/tb_func_table_scanner.sv
// Bench for func_table_scanner: the function block is modelled as an 8:1
// lookup on sel_out (or a stuck-at output), expected results are queued when a
// scan is started and checked when done pulses.
module tb_func_table_scanner;
    import func_scan_pkg::*;

    localparam int N_IN   = 3;
    localparam int SETTLE = 2;
    localparam int LAT    = 26;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] exp_table;
    logic       fn_in;
    logic [2:0] sel_out;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic       match;
    logic [3:0] mismatch_cnt;
    logic [2:0] first_bad_idx;

    typedef struct packed {
        logic [7:0] tbl;
        logic       m;
        logic [3:0] cnt;
        logic [2:0] first;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    // 0: table lookup, 1: stuck at 1, 2: stuck at 0
    int         mode      = 0;
    logic [7:0] model_tbl = FUNC_TABLE_DEF;

    always #5 clk = ~clk;

    assign fn_in = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : model_tbl[sel_out];

    func_table_scanner #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .exp_table     (exp_table),
        .fn_in         (fn_in),
        .sel_out       (sel_out),
        .busy          (busy),
        .done          (done),
        .table_out     (table_out),
        .match         (match),
        .mismatch_cnt  (mismatch_cnt),
        .first_bad_idx (first_bad_idx)
    );

    function automatic exp_t calc(input int md, input logic [7:0] tbl, input logic [7:0] ex);
        exp_t       r;
        logic [7:0] got;
        logic [7:0] diff;
        int         k;
        got     = (md == 1) ? 8'hFF : (md == 2) ? 8'h00 : tbl;
        diff    = got ^ ex;
        r.tbl   = got;
        r.m     = (diff == 8'h00);
        r.cnt   = 4'($countones(diff));
        r.first = 3'd0;
        k = 0;
        while (k < 8 && !diff[k]) k++;
        if (k < 8) r.first = 3'(k);
        return r;
    endfunction

    // Scoreboard: every done pulse consumes the oldest queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_unexpected_done: done=1 with no scan pending, want none");
            end else begin
                mon_e = sb.pop_front();
                total_cnt++;
                if (table_out !== mon_e.tbl)
                    $display("FAIL sb_table_out: got %h want %h", table_out, mon_e.tbl);
                else pass_cnt++;
                total_cnt++;
                if (match !== mon_e.m)
                    $display("FAIL sb_match: got %b want %b", match, mon_e.m);
                else pass_cnt++;
                total_cnt++;
                if (mismatch_cnt !== mon_e.cnt)
                    $display("FAIL sb_mismatch_cnt: got %0d want %0d", mismatch_cnt, mon_e.cnt);
                else pass_cnt++;
                total_cnt++;
                if (first_bad_idx !== mon_e.first)
                    $display("FAIL sb_first_bad_idx: got %0d want %0d", first_bad_idx, mon_e.first);
                else pass_cnt++;
            end
        end
    end

    // Starts a scan from an IDLE negedge and returns when done is seen (lat =
    // cycles from the start cycle, -1 on timeout). b1/s1 are busy/sel_out one
    // cycle after the start cycle.
    task automatic do_scan(input int md, input logic [7:0] tbl, input logic [7:0] ex,
                           input int chg_at, input logic [7:0] chg_val,
                           output int lat, output logic b1, output logic [2:0] s1);
        mode      = md;
        model_tbl = tbl;
        exp_table = ex;
        sb.push_back(calc(md, tbl, ex));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b1  = busy;
        s1  = sel_out;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            if (n == chg_at) exp_table = chg_val;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        start     = 1'b0;
        exp_table = 8'hA5;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({busy, done, sel_out} !== 5'b0)
            $display("FAIL reset_ctrl: busy/done/sel_out got %b want 00000", {busy, done, sel_out});
        else pass_cnt++;
        total_cnt++;
        if ({table_out, match, mismatch_cnt, first_bad_idx} !== 16'h0)
            $display("FAIL reset_results: got %h want 0000", {table_out, match, mismatch_cnt, first_bad_idx});
        else pass_cnt++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0)
            $display("FAIL idle_no_start: busy got %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_match;
        int         lat;
        logic       b1;
        logic [2:0] s1;
        do_scan(0, FUNC_TABLE_DEF, 8'h5A, -1, 8'h00, lat, b1, s1);
        total_cnt++;
        if (b1 !== 1'b1 || s1 !== 3'd0)
            $display("FAIL match_first_cycle: busy=%b sel=%0d want busy=1 sel=0", b1, s1);
        else pass_cnt++;
        total_cnt++;
        if (lat !== LAT)
            $display("FAIL match_latency: got %0d want %0d", lat, LAT);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL match_done_pulse: done=%b busy=%b want 0 0", done, busy);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (table_out !== 8'h5A || match !== 1'b1 || sel_out !== 3'd7)
            $display("FAIL match_hold: table=%h match=%b sel=%0d want 5a 1 7", table_out, match, sel_out);
        else pass_cnt++;
    endtask

    task automatic test_mismatch;
        int         md_t[4]  = '{0, 1, 0, 0};
        logic [7:0] tbl_t[4] = '{8'h5A, 8'h5A, 8'h5A, 8'hC3};
        logic [7:0] ex_t[4]  = '{8'h5B, 8'h5A, 8'h50, 8'h43};
        int         lat;
        logic       b1;
        logic [2:0] s1;
        for (int c = 0; c < 4; c++) begin
            do_scan(md_t[c], tbl_t[c], ex_t[c], -1, 8'h00, lat, b1, s1);
            total_cnt++;
            if (lat !== LAT)
                $display("FAIL mismatch_latency[%0d]: got %0d want %0d", c, lat, LAT);
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_latched_exp;
        int         lat;
        logic       b1;
        logic [2:0] s1;
        do_scan(2, 8'h5A, 8'hFF, 10, 8'h00, lat, b1, s1);
        total_cnt++;
        if (lat !== LAT)
            $display("FAIL latched_latency: got %0d want %0d", lat, LAT);
        else pass_cnt++;
        total_cnt++;
        if (mismatch_cnt !== 4'd8)
            $display("FAIL latched_cnt: got %0d want 8", mismatch_cnt);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        int         n;
        int         lat;
        logic       seen_done;
        logic       b1;
        logic [2:0] s1;
        mode      = 0;
        model_tbl = FUNC_TABLE_DEF;
        exp_table = 8'h5A;
        sb.push_back(calc(0, FUNC_TABLE_DEF, 8'h5A));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (sel_out !== 3'd4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total_cnt++;
        if (sel_out !== 3'd4)
            $display("FAIL abort_reach_sel4: sel got %0d want 4", sel_out);
        else pass_cnt++;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        sb.delete();
        total_cnt++;
        if ({busy, done, sel_out, table_out, match, mismatch_cnt, first_bad_idx} !== 21'h0)
            $display("FAIL abort_outputs: got %h want 0",
                     {busy, done, sel_out, table_out, match, mismatch_cnt, first_bad_idx});
        else pass_cnt++;
        seen_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        total_cnt++;
        if (seen_done !== 1'b0 || busy !== 1'b0)
            $display("FAIL abort_no_done: done_seen=%b busy=%b want 0 0", seen_done, busy);
        else pass_cnt++;
        do_scan(0, FUNC_TABLE_DEF, 8'h5A, -1, 8'h00, lat, b1, s1);
        total_cnt++;
        if (lat !== LAT || b1 !== 1'b1)
            $display("FAIL abort_rescan: lat=%0d busy=%b want %0d 1", lat, b1, LAT);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int   t_done[$];
        int   rise_t;
        int   sel_err;
        int   d0;
        int   d1;
        int   d2;
        logic prev_busy;
        mode      = 0;
        model_tbl = 8'h3C;
        exp_table = 8'h3C;
        repeat (3) sb.push_back(calc(0, 8'h3C, 8'h3C));
        start     = 1'b1;
        prev_busy = 1'b0;
        rise_t    = 0;
        sel_err   = 0;
        for (int cyc = 1; cyc <= 120 && t_done.size() < 3; cyc++) begin
            @(negedge clk);
            if (busy === 1'b1 && prev_busy !== 1'b1) rise_t = cyc;
            if (busy === 1'b1 && (cyc - rise_t) < 24) begin
                if (sel_out !== 3'((cyc - rise_t) / 3)) sel_err++;
            end
            if (done === 1'b1) t_done.push_back(cyc);
            prev_busy = busy;
        end
        start = 1'b0;
        d0 = (t_done.size() > 0) ? t_done[0] : -1;
        d1 = (t_done.size() > 1) ? t_done[1] - t_done[0] : -1;
        d2 = (t_done.size() > 2) ? t_done[2] - t_done[1] : -1;
        total_cnt++;
        if (t_done.size() != 3)
            $display("FAIL b2b_done_count: got %0d want 3", t_done.size());
        else pass_cnt++;
        total_cnt++;
        if (d0 != LAT || d1 != 27 || d2 != 27)
            $display("FAIL b2b_spacing: got %0d/%0d/%0d want %0d/27/27", d0, d1, d2, LAT);
        else pass_cnt++;
        total_cnt++;
        if (sel_err != 0)
            $display("FAIL b2b_sel_sequence: got %0d bad cycles want 0", sel_err);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0)
            $display("FAIL b2b_stop: busy got %b want 0", busy);
        else pass_cnt++;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        exp_table = 8'h00;
        test_reset;
        test_match;
        test_mismatch;
        test_latched_exp;
        test_reset_abort;
        test_back_to_back;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (sb.size() != 0)
            $display("FAIL sb_drained: got %0d pending want 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
